mips_mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS core. It replaces single-cycle decode with a Moore state machine that sequences the shared datapath (one memory port, one ALU, PC/IR/A/B/ALUOut registers) across 3–5 cycles per instruction. It sits beside the datapath inside `mips`: it takes opcode, funct and the ALU zero flag, and drives every register write-enable and mux select.

---
 rtl/mips_mc_pkg.sv | 52 +++++
 rtl/mips_alu_dec.sv | 43 ++++
 rtl/mips_mc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational ALU operation / immediate-extension decode from state, latched
// opcode and funct; flags unsupported funct codes while in EXEC.
module mips_alu_dec
  import mips_mc_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_ext_op,
  output logic       o_funct_ill
);

  always_comb begin
    o_alu_ctrl  = ALU_ADD;
    o_ext_op    = 1'b0;
    o_funct_ill = 1'b0;
    case (i_state)
      S_DECODE, S_MEMADR: o_ext_op = 1'b1;
      S_BRANCH:           o_alu_ctrl = ALU_SUB;
      S_EXEC: begin
        case (i_funct)
          FN_ADDU: o_alu_ctrl = ALU_ADD;
          FN_SUBU: o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_funct_ill = 1'b1;
        endcase
      end
      S_IEXEC: begin
        case (i_opcode)
          OP_ADDIU: o_ext_op   = 1'b1;
          OP_ORI:   o_alu_ctrl = ALU_OR;
          OP_LUI:   o_alu_ctrl = ALU_LUI;
          default:  o_alu_ctrl = ALU_ADD;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Moore FSM sequencing the shared multicycle datapath, 3-5 cycles/instruction.
// MC_STEP_EN adds a step input: one instruction per step, idling in between.
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       PcReSet,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MC_STEP_EN
  input  logic       step,
`endif
  output logic       PcEn,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [2:0] ALUCtrl,
  output logic [1:0] PcSrc,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

`ifdef MC_STEP_EN
  localparam state_t L_DONE = S_IDLE;
`else
  localparam state_t L_DONE = S_FETCH;
`endif

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;
  logic       w_pcwr;
  logic       w_pcwrcond;
  logic       w_funct_ill;

  always_ff @(posedge clk or negedge PcReSet) begin
    if (!PcReSet) begin
      r_state  <= S_IDLE;
      r_opcode <= 6'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= opcode;
    end
  end

  mips_alu_dec u_alu_dec (
    .i_state     (r_state),
    .i_opcode    (r_opcode),
    .i_funct     (funct),
    .o_alu_ctrl  (ALUCtrl),
    .o_ext_op    (ExtOp),
    .o_funct_ill (w_funct_ill)
  );

  always_comb begin
    w_next     = S_IDLE;
    w_pcwr     = 1'b0;
    w_pcwrcond = 1'b0;
    IorD       = 1'b0;
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    IRWr       = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    PcSrc      = PCSRC_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
`ifdef MC_STEP_EN
      S_IDLE:   w_next = step ? S_FETCH : S_IDLE;
`else
      S_IDLE:   w_next = S_FETCH;
`endif
      S_FETCH: begin
        MemRd   = 1'b1;
        IRWr    = 1'b1;
        w_pcwr  = 1'b1;
        ALUSrcB = SRCB_FOUR;
        w_next  = S_DECODE;
      end
      // Live opcode is only trusted here; later states use r_opcode.
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:            w_next = S_MEMADR;
          OP_RTYPE:                w_next = S_EXEC;
          OP_BEQ:                  w_next = S_BRANCH;
          OP_J:                    w_next = S_JUMP;
          OP_ADDIU, OP_ORI, OP_LUI: w_next = S_IEXEC;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            w_next     = L_DONE;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRd  = 1'b1;
        IorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWr      = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        w_next     = L_DONE;
      end
      S_MEMWR: begin
        MemWr      = 1'b1;
        IorD       = 1'b1;
        instr_done = 1'b1;
        w_next     = L_DONE;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (w_funct_ill) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          w_next     = L_DONE;
        end else begin
          w_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        RegWr      = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        w_next     = L_DONE;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        w_pcwrcond = 1'b1;
        PcSrc      = PCSRC_ALUOUT;
        instr_done = 1'b1;
        w_next     = L_DONE;
      end
      S_JUMP: begin
        w_pcwr     = 1'b1;
        PcSrc      = PCSRC_JUMP;
        instr_done = 1'b1;
        w_next     = L_DONE;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = S_IWB;
      end
      S_IWB: begin
        RegWr      = 1'b1;
        instr_done = 1'b1;
        w_next     = L_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign PcEn  = w_pcwr | (w_pcwrcond & zero);
  assign state = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-instruction state sequences and strobes,
// illegal handling, mid-instruction reset and (with MC_STEP_EN) single-stepping.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       PcReSet = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       step = 1'b0;
  logic       PcEn, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg, ALUSrcA;
  logic       ExtOp, instr_done, illegal;
  logic [1:0] ALUSrcB, PcSrc;
  logic [2:0] ALUCtrl;
  logic [3:0] state;
  logic [18:0] outs;

  int nchk = 0;
  int nerr = 0;

`ifdef MC_STEP_EN
  localparam logic [3:0] DONE_ST = 4'd0;
`else
  localparam logic [3:0] DONE_ST = 4'd1;
`endif

  always #5 clk = ~clk;

  assign outs = {PcEn, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg, ALUSrcA,
                 ALUSrcB, ExtOp, ALUCtrl, PcSrc, instr_done, illegal};

  mips_mc_ctrl dut (
    .clk(clk), .PcReSet(PcReSet), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MC_STEP_EN
    .step(step),
`endif
    .PcEn(PcEn), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr), .IRWr(IRWr),
    .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUCtrl(ALUCtrl), .PcSrc(PcSrc),
    .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In step mode the finishing state is IDLE; one more edge (step held high) refetches.
  task automatic back_to_fetch();
`ifdef MC_STEP_EN
    tick();
`endif
  endtask

  task automatic test_reset();
    #2 PcReSet = 1'b0;
`ifdef MC_STEP_EN
    step = 1'b1;
`endif
    #1;
    nchk++; if (state !== 4'd0) begin nerr++; $display("FAIL reset_async_state: got %0d want 0", state); end
    nchk++; if (outs !== 19'd0) begin nerr++; $display("FAIL reset_outputs: got %h want 0", outs); end
    tick(); tick();
    nchk++; if (state !== 4'd0) begin nerr++; $display("FAIL reset_hold_state: got %0d want 0", state); end
    PcReSet = 1'b1;
    nchk++; if (state !== 4'd0) begin nerr++; $display("FAIL release_cycle1: got %0d want 0", state); end
    tick();
    nchk++; if (state !== 4'd1) begin nerr++; $display("FAIL release_cycle2: got %0d want 1", state); end
    nchk++; if (MemRd !== 1'b1 || IRWr !== 1'b1) begin nerr++; $display("FAIL first_fetch_strobe: got %b%b want 11", MemRd, IRWr); end
  endtask

  task automatic test_lw();
    logic [3:0] st [6];
    logic [1:0] srcb;
    st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, DONE_ST};
    opcode = 6'h23;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) opcode = 6'h2B;
      #1;
      srcb = (st[i] == 4'd1) ? 2'd1 : (st[i] == 4'd2) ? 2'd3 : (st[i] == 4'd3) ? 2'd2 : 2'd0;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      nchk++; if (MemRd !== (st[i] == 4'd1 || st[i] == 4'd4)) begin nerr++; $display("FAIL lw_memrd[%0d]: got %b", i, MemRd); end
      nchk++; if (RegWr !== (st[i] == 4'd5) || MemtoReg !== (st[i] == 4'd5)) begin nerr++; $display("FAIL lw_regwr[%0d]: got %b%b", i, RegWr, MemtoReg); end
      nchk++; if (instr_done !== (st[i] == 4'd5)) begin nerr++; $display("FAIL lw_done[%0d]: got %b", i, instr_done); end
      nchk++; if (ALUSrcB !== srcb) begin nerr++; $display("FAIL lw_srcb[%0d]: got %0d want %0d", i, ALUSrcB, srcb); end
      nchk++; if (ExtOp !== (st[i] == 4'd2 || st[i] == 4'd3)) begin nerr++; $display("FAIL lw_extop[%0d]: got %b", i, ExtOp); end
      if (i < 5) tick();
    end
    back_to_fetch();
  endtask

  task automatic test_sw();
    logic [3:0] st [5];
    st = '{4'd1, 4'd2, 4'd3, 4'd6, DONE_ST};
    opcode = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) opcode = 6'h23;
      #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      nchk++; if (MemWr !== (st[i] == 4'd6) || IorD !== (st[i] == 4'd6)) begin nerr++; $display("FAIL sw_memwr[%0d]: got %b%b", i, MemWr, IorD); end
      nchk++; if (RegWr !== 1'b0) begin nerr++; $display("FAIL sw_regwr[%0d]: got %b want 0", i, RegWr); end
      if (i < 4) tick();
    end
    back_to_fetch();
  endtask

  task automatic test_beq();
    logic [3:0] st [4];
    st = '{4'd1, 4'd2, 4'd9, DONE_ST};
    opcode = 6'h04;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 4; i++) begin
        #1;
        nchk++; if (state !== st[i]) begin nerr++; $display("FAIL beq_state[z%0d,%0d]: got %0d want %0d", z, i, state, st[i]); end
        nchk++; if (PcEn !== (st[i] == 4'd1 || (st[i] == 4'd9 && z[0]))) begin nerr++; $display("FAIL beq_pcen[z%0d,%0d]: got %b", z, i, PcEn); end
        if (st[i] == 4'd9) begin
          nchk++; if (PcSrc !== 2'd1 || ALUCtrl !== 3'd1) begin nerr++; $display("FAIL beq_ctl[z%0d]: got pcsrc %0d alu %0d want 1 1", z, PcSrc, ALUCtrl); end
          nchk++; if (instr_done !== 1'b1) begin nerr++; $display("FAIL beq_done[z%0d]: got %b want 1", z, instr_done); end
        end
        if (i < 3) tick();
      end
      back_to_fetch();
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [3:0] st [4];
    st = '{4'd1, 4'd2, 4'd10, DONE_ST};
    opcode = 6'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL j_state[%0d]: got %0d want %0d", i, state, st[i]); end
      nchk++; if (PcEn !== (st[i] == 4'd1 || st[i] == 4'd10)) begin nerr++; $display("FAIL j_pcen[%0d]: got %b", i, PcEn); end
      nchk++; if (PcSrc !== ((st[i] == 4'd10) ? 2'd2 : 2'd0)) begin nerr++; $display("FAIL j_pcsrc[%0d]: got %0d", i, PcSrc); end
      if (i < 3) tick();
    end
    back_to_fetch();
  endtask

  task automatic test_rtype();
    logic [3:0] st [5];
    logic [5:0] fn [2];
    logic [2:0] alu [2];
    st = '{4'd1, 4'd2, 4'd7, 4'd8, DONE_ST};
    fn = '{6'h2A, 6'h23};
    alu = '{3'd4, 3'd1};
    opcode = 6'h00;
    for (int k = 0; k < 2; k++) begin
      funct = fn[k];
      for (int i = 0; i < 5; i++) begin
        #1;
        nchk++; if (state !== st[i]) begin nerr++; $display("FAIL r_state[f%h,%0d]: got %0d want %0d", fn[k], i, state, st[i]); end
        nchk++; if (ALUCtrl !== ((st[i] == 4'd7) ? alu[k] : 3'd0)) begin nerr++; $display("FAIL r_alu[f%h,%0d]: got %0d", fn[k], i, ALUCtrl); end
        nchk++; if (RegWr !== (st[i] == 4'd8) || RegDst !== (st[i] == 4'd8)) begin nerr++; $display("FAIL r_regwr[f%h,%0d]: got %b%b", fn[k], i, RegWr, RegDst); end
        nchk++; if (illegal !== 1'b0) begin nerr++; $display("FAIL r_illegal[f%h,%0d]: got %b want 0", fn[k], i, illegal); end
        if (i < 4) tick();
      end
      back_to_fetch();
    end
  endtask

  task automatic test_bad_funct();
    logic [3:0] st [4];
    st = '{4'd1, 4'd2, 4'd7, DONE_ST};
    opcode = 6'h00;
    funct = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL badfn_state[%0d]: got %0d want %0d", i, state, st[i]); end
      nchk++; if (illegal !== (st[i] == 4'd7) || instr_done !== (st[i] == 4'd7)) begin nerr++; $display("FAIL badfn_pulse[%0d]: got %b%b", i, illegal, instr_done); end
      nchk++; if (RegWr !== 1'b0) begin nerr++; $display("FAIL badfn_regwr[%0d]: got %b want 0", i, RegWr); end
      if (i < 3) tick();
    end
    back_to_fetch();
  endtask

  task automatic test_bad_opcode();
    logic [3:0] st [3];
    st = '{4'd1, 4'd2, DONE_ST};
    opcode = 6'h3E;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL badop_state[%0d]: got %0d want %0d", i, state, st[i]); end
      nchk++; if (illegal !== (st[i] == 4'd2) || instr_done !== (st[i] == 4'd2)) begin nerr++; $display("FAIL badop_pulse[%0d]: got %b%b", i, illegal, instr_done); end
      if (i < 2) tick();
    end
    back_to_fetch();
  endtask

  task automatic test_iexec();
    logic [3:0] st [5];
    logic [5:0] op [3];
    logic [2:0] alu [3];
    logic       ext [3];
    st = '{4'd1, 4'd2, 4'd11, 4'd12, DONE_ST};
    op = '{6'h0D, 6'h09, 6'h0F};
    alu = '{3'd3, 3'd0, 3'd5};
    ext = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      opcode = op[k];
      for (int i = 0; i < 5; i++) begin
        if (i == 2) opcode = 6'h23;
        #1;
        nchk++; if (state !== st[i]) begin nerr++; $display("FAIL i_state[op%h,%0d]: got %0d want %0d", op[k], i, state, st[i]); end
        if (st[i] == 4'd11) begin
          nchk++; if (ALUCtrl !== alu[k] || ExtOp !== ext[k]) begin nerr++; $display("FAIL i_aluext[op%h]: got %0d/%b want %0d/%b", op[k], ALUCtrl, ExtOp, alu[k], ext[k]); end
          nchk++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'd2) begin nerr++; $display("FAIL i_src[op%h]: got %b/%0d want 1/2", op[k], ALUSrcA, ALUSrcB); end
        end
        nchk++; if (RegWr !== (st[i] == 4'd12) || RegDst !== 1'b0 || MemtoReg !== 1'b0) begin nerr++; $display("FAIL i_wb[op%h,%0d]: got %b%b%b", op[k], i, RegWr, RegDst, MemtoReg); end
        if (i < 4) tick();
      end
      back_to_fetch();
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23;
    repeat (4) tick();
    nchk++; if (state !== 4'd5 || RegWr !== 1'b1) begin nerr++; $display("FAIL mid_pre: got state %0d regwr %b want 5 1", state, RegWr); end
    #2 PcReSet = 1'b0;
    #1;
    nchk++; if (RegWr !== 1'b0 || state !== 4'd0) begin nerr++; $display("FAIL mid_async: got regwr %b state %0d want 0 0", RegWr, state); end
    nchk++; if (outs !== 19'd0) begin nerr++; $display("FAIL mid_outs: got %h want 0", outs); end
    tick();
    nchk++; if (state !== 4'd0 || RegWr !== 1'b0) begin nerr++; $display("FAIL mid_hold: got state %0d regwr %b", state, RegWr); end
    PcReSet = 1'b1;
    tick();
    nchk++; if (state !== 4'd1) begin nerr++; $display("FAIL mid_release: got %0d want 1", state); end
  endtask

`ifdef MC_STEP_EN
  task automatic test_step();
    logic [3:0] st [6];
    st = '{4'd1, 4'd2, 4'd11, 4'd12, 4'd0, 4'd0};
    step = 1'b0;
    opcode = 6'h3E;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      nchk++; if (state !== 4'd0) begin nerr++; $display("FAIL step_idle[%0d]: got %0d want 0", i, state); end
      tick();
    end
    step = 1'b1;
    opcode = 6'h0D;
    tick();
    step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL step_state[%0d]: got %0d want %0d", i, state, st[i]); end
      if (st[i] == 4'd11) begin
        nchk++; if (ExtOp !== 1'b0 || ALUCtrl !== 3'd3) begin nerr++; $display("FAIL step_ori: got %b/%0d want 0/3", ExtOp, ALUCtrl); end
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_jump();
    test_rtype();
    test_bad_funct();
    test_bad_opcode();
    test_iexec();
    test_reset_mid();
`ifdef MC_STEP_EN
    test_step();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
